core2axil_bridge: RTL and testbench

Bridges the PULP core data port (req/gnt/rvalid) onto a flat AXI4-Lite master port, one transaction in flight. It is the parametrised successor to the fixed 32-bit core-to-AXI adapter, and sits between a core's LSU and the SoC AXI-Lite peripheral interconnect. Over the earlier adapter it adds:

- an AXI data bus width of 32 or 64 bits, with byte-lane steering;
- independent AW/W acceptance;
- response-error reporting;
- a configurable AxPROT value.

---
 rtl/core2axil_pkg.sv | 26 ++
 rtl/core2axil_lane_steer.sv | 29 ++
 rtl/core2axil_bridge.sv | 151 +++++++++++++++
 tb/tb_core2axil_bridge.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core2axil_pkg.sv
// Shared types and AXI response codes for the core-to-AXI4-Lite bridge.
package core2axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RSP,
        RD_REQ,
        RD_RSP,
        DONE
    } core2axil_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic resp_is_err(input logic [1:0] resp);
        case (resp)
            RESP_OKAY, RESP_EXOKAY:   return 1'b0;
            RESP_SLVERR, RESP_DECERR: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core2axil_lane_steer.sv
// Maps the 32-bit core data path onto a 32- or 64-bit AXI data bus.
module core2axil_lane_steer #(
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                        addr_hi_i,
    input  logic [3:0]                  be_i,
    input  logic [31:0]                 wdata_i,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_rdata_i,
    output logic [AXI_DATA_WIDTH-1:0]   axi_wdata_o,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb_o,
    output logic [31:0]                 rdata_o
);

    generate
        if (AXI_DATA_WIDTH == 64) begin : g_w64
            // Address bit 2 picks the 32-bit half; data is replicated so either half is valid.
            assign axi_wdata_o = {wdata_i, wdata_i};
            assign axi_wstrb_o = addr_hi_i ? {be_i, 4'b0000} : {4'b0000, be_i};
            assign rdata_o     = addr_hi_i ? axi_rdata_i[63:32] : axi_rdata_i[31:0];
        end else begin : g_w32
            logic unused_addr_hi;
            assign unused_addr_hi = addr_hi_i;
            assign axi_wdata_o    = wdata_i;
            assign axi_wstrb_o    = be_i;
            assign rdata_o        = axi_rdata_i;
        end
    endgenerate

endmodule

// File: rtl/core2axil_bridge.sv
// PULP core data port (req/gnt/rvalid) to AXI4-Lite master, one transaction in flight.
module core2axil_bridge
    import core2axil_pkg::*;
#(
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter int          AXI_DATA_WIDTH = 32,
    parameter logic [2:0]  AXI_PROT       = 3'b000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        data_req_i,
    output logic                        data_gnt_o,
    output logic                        data_rvalid_o,
    output logic                        data_err_o,
    input  logic [AXI_ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                        data_we_i,
    input  logic [3:0]                  data_be_i,
    input  logic [31:0]                 data_wdata_i,
    output logic [31:0]                 data_rdata_o,
    output logic                        axi_awvalid_o,
    input  logic                        axi_awready_i,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr_o,
    output logic [2:0]                  axi_awprot_o,
    output logic                        axi_wvalid_o,
    input  logic                        axi_wready_i,
    output logic [AXI_DATA_WIDTH-1:0]   axi_wdata_o,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb_o,
    input  logic                        axi_bvalid_i,
    output logic                        axi_bready_o,
    input  logic [1:0]                  axi_bresp_i,
    output logic                        axi_arvalid_o,
    input  logic                        axi_arready_i,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_araddr_o,
    output logic [2:0]                  axi_arprot_o,
    input  logic                        axi_rvalid_i,
    output logic                        axi_rready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_rdata_i,
    input  logic [1:0]                  axi_rresp_i
);

    core2axil_state_e          state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]                be_q, be_d;
    logic [31:0]               wdata_q, wdata_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      err_q, err_d;
    logic [31:0]               rdata_q, rdata_d;
    logic [31:0]               rdata_steered;

    core2axil_lane_steer #(
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH)
    ) u_lane_steer (
        .addr_hi_i   (addr_q[2]),
        .be_i        (be_q),
        .wdata_i     (wdata_q),
        .axi_rdata_i (axi_rdata_i),
        .axi_wdata_o (axi_wdata_o),
        .axi_wstrb_o (axi_wstrb_o),
        .rdata_o     (rdata_steered)
    );

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (data_req_i) begin
                    addr_d    = data_addr_i;
                    be_d      = data_be_i;
                    wdata_d   = data_wdata_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    err_d     = 1'b0;
                    rdata_d   = '0;
                    state_d   = data_we_i ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                aw_done_d = aw_done_q | axi_awready_i;
                w_done_d  = w_done_q | axi_wready_i;
                if (aw_done_d && w_done_d) state_d = WR_RSP;
            end
            WR_RSP: begin
                if (axi_bvalid_i) begin
                    err_d   = resp_is_err(axi_bresp_i);
                    state_d = DONE;
                end
            end
            RD_REQ: begin
                if (axi_arready_i) state_d = RD_RSP;
            end
            RD_RSP: begin
                if (axi_rvalid_i) begin
                    rdata_d = rdata_steered;
                    err_d   = resp_is_err(axi_rresp_i);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Grant is gated by reset so a request held through reset is not accepted early.
    assign data_gnt_o    = data_req_i && (state_q == IDLE) && !rst_i;
    assign data_rvalid_o = (state_q == DONE);
    assign data_err_o    = err_q;
    assign data_rdata_o  = rdata_q;

    assign axi_awvalid_o = (state_q == WR_REQ) && !aw_done_q;
    assign axi_wvalid_o  = (state_q == WR_REQ) && !w_done_q;
    assign axi_bready_o  = (state_q == WR_RSP);
    assign axi_arvalid_o = (state_q == RD_REQ);
    assign axi_rready_o  = (state_q == RD_RSP);
    assign axi_awaddr_o  = addr_q;
    assign axi_araddr_o  = addr_q;
    assign axi_awprot_o  = AXI_PROT;
    assign axi_arprot_o  = AXI_PROT;

endmodule

// File: tb/tb_core2axil_bridge.sv
// Drives a 32-bit and a 64-bit bridge against a behavioural AXI-Lite slave and core model.
module tb_core2axil_bridge;

    localparam logic [2:0] PROT0 = 3'b101;
    localparam logic [2:0] PROT1 = 3'b010;

    logic        clk;
    logic        rst;
    int          checks;
    int          failures;

    logic        req [2];
    logic        gnt [2];
    logic        rvalid_o [2];
    logic        err [2];
    logic        we [2];
    logic [31:0] addr [2];
    logic [3:0]  be [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata_o [2];
    logic        awvalid [2], awready [2], wvalid [2], wready [2];
    logic        bvalid [2], bready [2], arvalid [2], arready [2];
    logic        rvalid [2], rready [2];
    logic [31:0] awaddr [2], araddr [2];
    logic [2:0]  awprot [2], arprot [2];
    logic [63:0] w_data [2], r_data [2];
    logic [7:0]  wstrb [2];
    logic [1:0]  bresp [2], rresp [2];
    logic [31:0] d0_wdata;
    logic [3:0]  d0_wstrb;
    logic [63:0] d1_wdata;
    logic [7:0]  d1_wstrb;

    assign w_data[0] = {32'h0, d0_wdata};
    assign wstrb[0]  = {4'h0, d0_wstrb};
    assign w_data[1] = d1_wdata;
    assign wstrb[1]  = d1_wstrb;

    core2axil_bridge #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_PROT(PROT0)) u_dut32 (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req[0]), .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid_o[0]), .data_err_o(err[0]),
        .data_addr_i(addr[0]), .data_we_i(we[0]), .data_be_i(be[0]), .data_wdata_i(wdata[0]),
        .data_rdata_o(rdata_o[0]),
        .axi_awvalid_o(awvalid[0]), .axi_awready_i(awready[0]), .axi_awaddr_o(awaddr[0]), .axi_awprot_o(awprot[0]),
        .axi_wvalid_o(wvalid[0]), .axi_wready_i(wready[0]), .axi_wdata_o(d0_wdata), .axi_wstrb_o(d0_wstrb),
        .axi_bvalid_i(bvalid[0]), .axi_bready_o(bready[0]), .axi_bresp_i(bresp[0]),
        .axi_arvalid_o(arvalid[0]), .axi_arready_i(arready[0]), .axi_araddr_o(araddr[0]), .axi_arprot_o(arprot[0]),
        .axi_rvalid_i(rvalid[0]), .axi_rready_o(rready[0]), .axi_rdata_i(r_data[0][31:0]), .axi_rresp_i(rresp[0])
    );

    core2axil_bridge #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_PROT(PROT1)) u_dut64 (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req[1]), .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid_o[1]), .data_err_o(err[1]),
        .data_addr_i(addr[1]), .data_we_i(we[1]), .data_be_i(be[1]), .data_wdata_i(wdata[1]),
        .data_rdata_o(rdata_o[1]),
        .axi_awvalid_o(awvalid[1]), .axi_awready_i(awready[1]), .axi_awaddr_o(awaddr[1]), .axi_awprot_o(awprot[1]),
        .axi_wvalid_o(wvalid[1]), .axi_wready_i(wready[1]), .axi_wdata_o(d1_wdata), .axi_wstrb_o(d1_wstrb),
        .axi_bvalid_i(bvalid[1]), .axi_bready_o(bready[1]), .axi_bresp_i(bresp[1]),
        .axi_arvalid_o(arvalid[1]), .axi_arready_i(arready[1]), .axi_araddr_o(araddr[1]), .axi_arprot_o(arprot[1]),
        .axi_rvalid_i(rvalid[1]), .axi_rready_o(rready[1]), .axi_rdata_i(r_data[1]), .axi_rresp_i(rresp[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs(input int d);
        req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; be[d] = '0; wdata[d] = '0;
        awready[d] = 1'b0; wready[d] = 1'b0; bvalid[d] = 1'b0; arready[d] = 1'b0; rvalid[d] = 1'b0;
        bresp[d] = '0; rresp[d] = '0; r_data[d] = '0;
    endtask

    // One complete core transaction on bridge d with per-channel slave delays (in cycles).
    task automatic do_txn(input int d, input logic twe, input logic [31:0] taddr, input logic [3:0] tbe,
                          input logic [31:0] twd, input logic [63:0] trd, input logic [1:0] tresp,
                          input int daw, input int dw, input int db, input int dar, input int dr,
                          input bit keep, input string name);
        logic [63:0] exp_wd;
        logic [7:0]  exp_strb;
        logic [31:0] exp_rd;
        logic        exp_err, exp_aw, exp_w, exp_ar, exp_b, exp_r, exp_rv, bv, rv;
        logic [2:0]  exp_prot;
        int aw_n, w_n, b_n, ar_n, r_n, aw_wait, w_wait, b_wait, ar_wait, r_wait;
        bit got;
        exp_err  = (tresp == 2'b10) || (tresp == 2'b11);
        exp_prot = (d == 1) ? PROT1 : PROT0;
        if (d == 1) begin
            exp_wd   = {twd, twd};
            exp_strb = 8'(tbe) << (taddr[2] ? 4 : 0);
            exp_rd   = taddr[2] ? trd[63:32] : trd[31:0];
        end else begin
            exp_wd   = {32'h0, twd};
            exp_strb = {4'h0, tbe};
            exp_rd   = trd[31:0];
        end
        if (twe) exp_rd = 32'h0;

        @(negedge clk);
        checks++;
        if (rvalid_o[d] !== 1'b0) begin failures++; $display("FAIL %s idle_rvalid: got %b want 0", name, rvalid_o[d]); end
        req[d] = 1'b1; we[d] = twe; addr[d] = taddr; be[d] = tbe; wdata[d] = twd;
        #1;
        checks++;
        if (gnt[d] !== 1'b1) begin failures++; $display("FAIL %s gnt: got %b want 1", name, gnt[d]); end

        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        got = 0;
        for (int cyc = 1; cyc <= 60 && !got; cyc++) begin
            @(negedge clk);
            if (!keep) req[d] = 1'b0;
            addr[d] = $urandom; wdata[d] = $urandom; be[d] = 4'($urandom); we[d] = 1'($urandom);
            #1;
            exp_aw = twe && (aw_n == 0);
            exp_w  = twe && (w_n == 0);
            exp_b  = twe && (aw_n == 1) && (w_n == 1) && (b_n == 0);
            exp_ar = !twe && (ar_n == 0);
            exp_r  = !twe && (ar_n == 1) && (r_n == 0);
            exp_rv = twe ? (b_n == 1) : (r_n == 1);
            checks++;
            if (gnt[d] !== 1'b0) begin failures++; $display("FAIL %s gnt_busy: got %b want 0", name, gnt[d]); end
            checks++;
            if (awvalid[d] !== exp_aw) begin failures++; $display("FAIL %s awvalid c%0d: got %b want %b", name, cyc, awvalid[d], exp_aw); end
            checks++;
            if (wvalid[d] !== exp_w) begin failures++; $display("FAIL %s wvalid c%0d: got %b want %b", name, cyc, wvalid[d], exp_w); end
            checks++;
            if (bready[d] !== exp_b) begin failures++; $display("FAIL %s bready c%0d: got %b want %b", name, cyc, bready[d], exp_b); end
            checks++;
            if (arvalid[d] !== exp_ar) begin failures++; $display("FAIL %s arvalid c%0d: got %b want %b", name, cyc, arvalid[d], exp_ar); end
            checks++;
            if (rready[d] !== exp_r) begin failures++; $display("FAIL %s rready c%0d: got %b want %b", name, cyc, rready[d], exp_r); end
            checks++;
            if (rvalid_o[d] !== exp_rv) begin failures++; $display("FAIL %s rvalid c%0d: got %b want %b", name, cyc, rvalid_o[d], exp_rv); end
            if (exp_aw) begin
                checks++;
                if (awaddr[d] !== taddr || awprot[d] !== exp_prot) begin
                    failures++; $display("FAIL %s awaddr/prot: got %h/%b want %h/%b", name, awaddr[d], awprot[d], taddr, exp_prot);
                end
            end
            if (exp_w) begin
                checks++;
                if (w_data[d] !== exp_wd || wstrb[d] !== exp_strb) begin
                    failures++; $display("FAIL %s wdata/strb: got %h/%h want %h/%h", name, w_data[d], wstrb[d], exp_wd, exp_strb);
                end
            end
            if (exp_ar) begin
                checks++;
                if (araddr[d] !== taddr || arprot[d] !== exp_prot) begin
                    failures++; $display("FAIL %s araddr/prot: got %h/%b want %h/%b", name, araddr[d], arprot[d], taddr, exp_prot);
                end
            end
            if (exp_rv) begin
                got = 1;
                checks++;
                if (err[d] !== exp_err) begin failures++; $display("FAIL %s err: got %b want %b", name, err[d], exp_err); end
                checks++;
                if (rdata_o[d] !== exp_rd) begin failures++; $display("FAIL %s rdata: got %h want %h", name, rdata_o[d], exp_rd); end
                if (daw == 0 && dw == 0 && db == 0 && dar == 0 && dr == 0) begin
                    checks++;
                    if (cyc != 3) begin failures++; $display("FAIL %s latency: got %0d want 3", name, cyc); end
                end
            end

            // Slave responses depend only on handshakes completed at earlier edges.
            bv = twe && (aw_n == 1) && (w_n == 1) && (b_n == 0) && (b_wait >= db);
            rv = !twe && (ar_n == 1) && (r_n == 0) && (r_wait >= dr);
            bvalid[d] = bv;
            bresp[d]  = bv ? tresp : 2'($urandom);
            rvalid[d] = rv;
            rresp[d]  = rv ? tresp : 2'($urandom);
            r_data[d] = rv ? trd : {$urandom, $urandom};
            if (bv && bready[d]) b_n++;
            else if (twe && aw_n == 1 && w_n == 1 && b_n == 0) b_wait++;
            if (rv && rready[d]) r_n++;
            else if (!twe && ar_n == 1 && r_n == 0) r_wait++;

            awready[d] = awvalid[d] && (aw_n == 0) && (aw_wait >= daw);
            wready[d]  = wvalid[d] && (w_n == 0) && (w_wait >= dw);
            arready[d] = arvalid[d] && (ar_n == 0) && (ar_wait >= dar);
            if (awvalid[d] && aw_n == 0) begin if (awready[d]) aw_n++; else aw_wait++; end
            if (wvalid[d] && w_n == 0) begin if (wready[d]) w_n++; else w_wait++; end
            if (arvalid[d] && ar_n == 0) begin if (arready[d]) ar_n++; else ar_wait++; end
        end
        checks++;
        if (!got) begin failures++; $display("FAIL %s timeout: got no rvalid want rvalid within 60 cycles", name); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs(0);
        clear_inputs(1);
        repeat (3) @(negedge clk);
        req[0] = 1'b1; req[1] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({gnt[d], rvalid_o[d], err[d], awvalid[d], wvalid[d], bready[d], arvalid[d], rready[d]} !== 8'h00) begin
                failures++;
                $display("FAIL reset_ctrl d%0d: got %b want 00000000", d,
                         {gnt[d], rvalid_o[d], err[d], awvalid[d], wvalid[d], bready[d], arvalid[d], rready[d]});
            end
            checks++;
            if (rdata_o[d] !== 32'h0) begin failures++; $display("FAIL reset_rdata d%0d: got %h want 0", d, rdata_o[d]); end
        end
        req[0] = 1'b0; req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_zero_wait();
        do_txn(0, 1'b1, 32'h1000_0004, 4'hF, 32'hDEAD_BEEF, 64'h0, 2'b00, 0, 0, 0, 0, 0, 1'b0, "wr32_zero_wait");
        do_txn(0, 1'b0, 32'h1000_0008, 4'hF, 32'h0, 64'h5555_6666_7777_8888, 2'b00, 0, 0, 0, 0, 0, 1'b0, "rd32_zero_wait");
    endtask

    task automatic test_skewed_aw_w();
        do_txn(0, 1'b1, 32'h1000_0010, 4'h6, 32'hCAFE_F00D, 64'h0, 2'b00, 0, 3, 0, 0, 0, 1'b0, "skew_w_late");
        do_txn(1, 1'b1, 32'h1000_0014, 4'h9, 32'h0BAD_F00D, 64'h0, 2'b00, 2, 0, 1, 0, 0, 1'b0, "skew_aw_late");
    endtask

    task automatic test_lane_steer_64();
        do_txn(1, 1'b1, 32'h2000_0004, 4'b0011, 32'h1234_5678, 64'h0, 2'b00, 0, 0, 0, 0, 0, 1'b0, "w64_hi_lane");
        do_txn(1, 1'b1, 32'h2000_0003, 4'b1010, 32'h8765_4321, 64'h0, 2'b00, 0, 0, 0, 0, 0, 1'b0, "w64_lo_lane");
        do_txn(1, 1'b0, 32'h2000_0004, 4'hF, 32'h0, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 0, 0, 0, 0, 0, 1'b0, "r64_hi_lane");
        do_txn(1, 1'b0, 32'h2000_0008, 4'hF, 32'h0, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 0, 0, 0, 1, 2, 1'b0, "r64_lo_lane");
    endtask

    task automatic test_error_resp();
        for (int d = 0; d < 2; d++) begin
            do_txn(d, 1'b0, 32'h3000_0000, 4'hF, 32'h0, 64'h1111_2222_3333_4444, 2'b10, 0, 0, 0, 0, 0, 1'b0, "rd_slverr");
            do_txn(d, 1'b1, 32'h3000_0004, 4'hF, 32'h1, 64'h0, 2'b11, 0, 0, 0, 0, 0, 1'b0, "wr_decerr");
            do_txn(d, 1'b1, 32'h3000_0008, 4'hF, 32'h2, 64'h0, 2'b01, 0, 0, 0, 0, 0, 1'b0, "wr_exokay");
            do_txn(d, 1'b0, 32'h3000_000C, 4'hF, 32'h0, 64'h9999_8888_7777_6666, 2'b11, 0, 0, 0, 0, 0, 1'b0, "rd_decerr");
        end
    endtask

    task automatic test_back_to_back();
        do_txn(1, 1'b1, 32'h4000_0000, 4'hF, 32'hA5A5_0001, 64'h0, 2'b00, 0, 0, 0, 0, 0, 1'b1, "b2b_0");
        do_txn(1, 1'b0, 32'h4000_0004, 4'hF, 32'h0, 64'hFEED_0002_BEEF_0002, 2'b00, 0, 0, 0, 0, 0, 1'b1, "b2b_1");
        do_txn(1, 1'b1, 32'h4000_0008, 4'hC, 32'hA5A5_0003, 64'h0, 2'b10, 1, 0, 0, 0, 0, 1'b0, "b2b_2");
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h5000_0000; be[0] = 4'hF; wdata[0] = 32'h7777_7777;
        #1;
        checks++;
        if (gnt[0] !== 1'b1) begin failures++; $display("FAIL rst_mid gnt: got %b want 1", gnt[0]); end
        @(negedge clk);
        awready[0] = 1'b1; wready[0] = 1'b0;
        #1;
        checks++;
        if (wvalid[0] !== 1'b1) begin failures++; $display("FAIL rst_mid wvalid_pre: got %b want 1", wvalid[0]); end
        @(negedge clk);
        awready[0] = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt[0], rvalid_o[0], awvalid[0], wvalid[0], bready[0], arvalid[0], rready[0], err[0]} !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid async: got %b want 00000000",
                     {gnt[0], rvalid_o[0], awvalid[0], wvalid[0], bready[0], arvalid[0], rready[0], err[0]});
        end
        @(negedge clk);
        req[0] = 1'b0;
        rst = 1'b0;
        do_txn(0, 1'b0, 32'h5000_0010, 4'hF, 32'h0, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0, 0, 0, 0, 1'b0, "rst_mid_fresh_rd");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int d;
            d = i % 2;
            do_txn(d, 1'($urandom), $urandom, 4'($urandom), $urandom, {$urandom, $urandom}, 2'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, "random");
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_zero_wait();
        test_skewed_aw_w();
        test_lane_steer_64();
        test_error_resp();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
